// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Holds the arbiter state type, the byte width and the clog2 helpers used to
// size the grant index and the hold-timeout counter.
package uart_tx_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_HOLD
  } arb_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Ceiling log2 with a floor of one bit, for index and counter widths.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bus between the requesters, the arbiter and the UART byte transmitter.
//   req / req_data / req_last : requester byte offers (req_data byte i at [8i+7:8i])
//   req_ack                   : one-cycle accept pulse per requester
//   grant_id / arb_busy       : arbiter status
//   tx_data / tx_start        : byte and start pulse towards the transmitter
//   tx_busy / tx_done         : transmitter progress
// Modport slave is the arbiter view; master is the requester/transmitter view.
interface uart_tx_arb_if
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GID_W = 2
);

  logic [N_REQ-1:0]        req;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ack;
  logic [GID_W-1:0]        grant_id;
  logic                    arb_busy;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    tx_done;

  modport slave (
    input  req, req_data, req_last, tx_busy, tx_done,
    output req_ack, grant_id, arb_busy, tx_data, tx_start
  );

  modport master (
    output req, req_data, req_last, tx_busy, tx_done,
    input  req_ack, grant_id, arb_busy, tx_data, tx_start
  );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   last_id : index granted last; search starts at last_id+1 and wraps
//   win_id  : first requesting index found
//   win_vld : at least one request is set
module uart_tx_arb_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] last_id,
  output logic [GID_W-1:0] win_id,
  output logic             win_vld
);

  always_comb begin
    logic [GID_W-1:0] idx;
    win_id  = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = GID_W'((32'(last_id) + off) % N_REQ);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ requesters.
// Issues one byte at a time, follows the transmitter through busy/done and,
// with LOCK_EN, keeps the grant on one requester until its req_last byte.
//   clk_i : system clock
//   rst_n : asynchronous active-low reset
//   bus   : requester and transmitter signals (see uart_tx_arb_if)
// All outputs are registered; there is no combinational path from req.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned GID_W   = clog2_min1(N_REQ),
  parameter bit          LOCK_EN = 1'b1,
  parameter int unsigned HOLD_TO = 65535
) (
  input  logic         clk_i,
  input  logic         rst_n,
  uart_tx_arb_if.slave bus
);

  localparam int unsigned CNT_W = clog2_min1(HOLD_TO + 1);

  arb_state_e        state_q, state_d;
  logic [GID_W-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [GID_W-1:0]  pick_id;
  logic              pick_vld;
  logic              issue;
  logic [GID_W-1:0]  issue_id;
  logic              done_exit;

  uart_tx_arb_rr_pick #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_pick (
    .req     (bus.req),
    .last_id (grant_q),
    .win_id  (pick_id),
    .win_vld (pick_vld)
  );

  // IDLE and HOLD both end in the same issue step; a done seen in WAIT_BUSY
  // takes the WAIT_DONE exit directly, so both states share done_exit.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    issue      = 1'b0;
    issue_id   = grant_q;
    done_exit  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          issue    = 1'b1;
          issue_id = pick_id;
        end
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_done) done_exit = 1'b1;
        else if (bus.tx_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done) done_exit = 1'b1;
      end
      ST_HOLD: begin
        if (bus.req[grant_q]) begin
          issue = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_d == CNT_W'(HOLD_TO)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_exit) begin
      if (LOCK_EN && !last_q) begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (issue) begin
      state_d         = ST_WAIT_BUSY;
      grant_d         = issue_id;
      ack_d[issue_id] = 1'b1;
      tx_data_d       = bus.req_data[issue_id*BYTE_W +: BYTE_W];
      tx_start_d      = 1'b1;
      last_d          = bus.req_last[issue_id];
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= GID_W'(N_REQ - 1);
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.req_ack  = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.arb_busy = busy_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_uart_tx_arb;

  localparam int N    = 4;
  localparam int HTO  = 16;
  localparam bit LOCK = 1'b1;

  localparam int FAIR[6]      = '{0, 1, 2, 3, 0, 1};
  localparam int LOCK_ID[4]   = '{1, 1, 1, 3};
  localparam int LOCK_DATA[4] = '{8'h01, 8'h02, 8'h03, 8'h33};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N), .GID_W(2)) bus ();

  uart_tx_arb #(
    .N_REQ   (N),
    .GID_W   (2),
    .LOCK_EN (LOCK),
    .HOLD_TO (HTO)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0: free (arbitrate), 1: byte in flight (wait for done), 2: locked to m_gid
  int         m_phase;
  int         m_gid;
  int         m_idle;
  bit         m_last;
  logic [3:0] m_ack;
  logic       m_start;
  logic [7:0] m_data;
  logic       m_busy;

  task automatic model_reset();
    m_phase = 0; m_gid = N - 1; m_idle = 0; m_last = 1'b0;
    m_ack = '0; m_start = 1'b0; m_data = '0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    int w;
    w = -1;
    m_ack   = '0;
    m_start = 1'b0;
    if (m_phase == 0) begin
      for (int k = 1; k <= N; k++)
        if (w < 0 && bus.req[(m_gid + k) % N]) w = (m_gid + k) % N;
    end else if (m_phase == 1) begin
      if (bus.tx_done) begin
        m_phase = (LOCK && !m_last) ? 2 : 0;
        m_idle  = 0;
      end
    end else begin
      if (bus.req[m_gid]) w = m_gid;
      else begin
        m_idle++;
        if (m_idle == HTO) m_phase = 0;
      end
    end
    if (w >= 0) begin
      m_gid    = w;
      m_phase  = 1;
      m_last   = bus.req_last[w];
      m_ack[w] = 1'b1;
      m_start  = 1'b1;
      m_data   = bus.req_data[8*w +: 8];
    end
    m_busy = (m_phase != 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ack",   bus.req_ack,  m_ack);
      chk("m_start", bus.tx_start, m_start);
      chk("m_data",  bus.tx_data,  m_data);
      chk("m_gid",   bus.grant_id, m_gid);
      chk("m_busy",  bus.arb_busy, m_busy);
    end
  end

  // ---------------- stimulus ----------------
  bit tx_act = 1'b0, tx_fast = 1'b0, tx_rand = 1'b0, rand_mode = 1'b0;
  int tx_t = 0, tx_busy_at = 1, tx_done_at = 4;

  task automatic new_byte(input int i);
    bus.req[i]           = 1'b1;
    bus.req_data[8*i +: 8] = 8'($urandom);
    bus.req_last[i]      = ($urandom_range(0, 2) != 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    if (bus.tx_start) begin
      tx_act = 1'b1;
      tx_t   = 0;
      if (tx_rand) begin
        tx_fast    = ($urandom_range(0, 3) == 0);
        tx_busy_at = $urandom_range(0, 2);
        tx_done_at = tx_busy_at + $urandom_range(1, 6);
      end
    end else if (tx_act) begin
      tx_t++;
    end
    bus.tx_busy = tx_act && !tx_fast && (tx_t >= tx_busy_at) && (tx_t < tx_done_at);
    bus.tx_done = tx_act && (tx_t == tx_done_at);
    if (bus.tx_done) tx_act = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_ack[i]) begin
          if ($urandom_range(0, 3) != 0) new_byte(i);
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 7) == 0) new_byte(i);
        end else if ($urandom_range(0, 63) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_ack(input int limit, output int who);
    who = -1;
    for (int c = 0; c < limit; c++) begin
      cycle();
      if (bus.req_ack != '0) begin
        for (int i = 0; i < N; i++) if (bus.req_ack[i]) who = i;
        chk("ack_onehot", $countones(bus.req_ack), 1);
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL ack_timeout: no req_ack within %0d cycles, want one", limit);
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    bus.req      = '0;
    bus.req_last = '0;
    while (tx_act && n < 64) begin
      cycle();
      n++;
    end
    cycle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want $finish");
    $fatal(1);
  end

  initial begin
    int who;
    int k;
    bus.req = '0; bus.req_data = '0; bus.req_last = '0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0;

    // reset values
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    chk("rst_ack",   bus.req_ack,  4'b0000);
    chk("rst_start", bus.tx_start, 1'b0);
    chk("rst_data",  bus.tx_data,  8'h00);
    chk("rst_busy",  bus.arb_busy, 1'b0);
    chk("rst_gid",   bus.grant_id, 2'd3);

    // single requester
    tx_busy_at = 1; tx_done_at = 5;
    bus.req = 4'b0100; bus.req_data = 32'h005A_0000; bus.req_last = 4'b0100;
    cycle();
    chk("one_ack",   bus.req_ack,  4'b0100);
    chk("one_start", bus.tx_start, 1'b1);
    chk("one_data",  bus.tx_data,  8'h5A);
    chk("one_gid",   bus.grant_id, 2'd2);
    bus.req = '0;
    k = 0;
    while (!bus.tx_done && k < 20) begin cycle(); k++; end
    cycle();
    chk("one_idle", bus.arb_busy, 1'b0);

    // fairness with every byte marked last
    do_reset();
    tx_busy_at = 1; tx_done_at = 20;
    bus.req = 4'hF; bus.req_last = 4'hF; bus.req_data = 32'h1312_1110;
    for (int g = 0; g < 6; g++) begin
      wait_ack(60, who);
      chk("fair_id", who, FAIR[g]);
    end

    // packet lock
    do_reset();
    tx_busy_at = 1; tx_done_at = 4;
    bus.req = 4'b1010; bus.req_data = 32'h3300_0100; bus.req_last = 4'b1000;
    for (int b = 0; b < 4; b++) begin
      wait_ack(60, who);
      chk("lock_id",   who,         LOCK_ID[b]);
      chk("lock_data", bus.tx_data, LOCK_DATA[b]);
      if (who == 1) begin
        if (b == 0) bus.req_data[15:8] = 8'h02;
        else if (b == 1) begin bus.req_data[15:8] = 8'h03; bus.req_last[1] = 1'b1; end
        else bus.req[1] = 1'b0;
      end else begin
        bus.req[3] = 1'b0;
      end
    end

    // hold timeout: done seen, then HTO hold cycles, one IDLE cycle, then ack
    do_reset();
    tx_busy_at = 1; tx_done_at = 3;
    bus.req = 4'b0001; bus.req_data = 32'h00C2_00A0; bus.req_last = 4'b0000;
    wait_ack(10, who);
    chk("hold_first", who, 0);
    bus.req = 4'b0100; bus.req_last = 4'b0100;
    k = 0;
    while (!bus.tx_done && k < 20) begin cycle(); k++; end
    k = 0;
    do begin cycle(); k++; end while (bus.req_ack == '0 && k < 40);
    chk("hold_lat",  k,            18);
    chk("hold_ack",  bus.req_ack,  4'b0100);
    chk("hold_data", bus.tx_data,  8'hC2);
    bus.req = '0;

    // transmitter that never raises busy
    do_reset();
    tx_fast = 1'b1; tx_done_at = 2;
    bus.req = 4'b0011; bus.req_last = 4'b0011; bus.req_data = 32'h0000_B1B0;
    wait_ack(10, who);
    chk("fast_id0", who, 0);
    bus.req[0] = 1'b0;
    wait_ack(10, who);
    chk("fast_id1", who, 1);
    bus.req = '0;
    tx_fast = 1'b0;

    // asynchronous reset while waiting for done
    do_reset();
    tx_busy_at = 1; tx_done_at = 10;
    bus.req = 4'b0010; bus.req_last = 4'b0010; bus.req_data = 32'h0000_BE00;
    wait_ack(10, who);
    bus.req = '0;
    repeat (3) cycle();
    chk("mid_busy", bus.arb_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ack",   bus.req_ack,  4'b0000);
    chk("mid_start", bus.tx_start, 1'b0);
    chk("mid_data",  bus.tx_data,  8'h00);
    chk("mid_idle",  bus.arb_busy, 1'b0);
    chk("mid_gid",   bus.grant_id, 2'd3);
    cycle(); cycle();
    rst_n = 1'b1;
    bus.req = 4'hF; bus.req_last = 4'hF;
    wait_ack(10, who);
    chk("mid_first", who, 0);
    bus.req = '0;

    // randomized traffic
    do_reset();
    tx_rand = 1'b1;
    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    bus.req = '0;
    repeat (60) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one UART byte transmitter among N_REQ byte-producing requesters (loopback echo, status reporter, debug dump, etc.).
- Sits between the requesters and the transmitter's byte interface. Issues one byte at a time and tracks the transmitter through busy/done.
- Optional packet lock keeps the grant on one requester until it marks its last byte, so multi-byte messages are not interleaved.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GID_W, 2, grant index width = clog2(N_REQ), minimum 1.
- LOCK_EN, 1, 1 = hold grant until the byte flagged req_last is sent; 0 = re-arbitrate after every byte.
- HOLD_TO, 65535, max idle cycles in HOLD before the lock is force-released (must be >= 1; counter width clog2(HOLD_TO+1)).

Ports:
- clk_i, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- req, input, N_REQ, per-requester byte request; held high with data stable until acked.
- req_data, input, 8*N_REQ, byte of requester i on bits [8i+7:8i].
- req_last, input, N_REQ, byte presented is the last of a packet (sampled with req).
- req_ack, output, N_REQ, one-cycle pulse: byte of requester i accepted.
- grant_id, output, GID_W, index of current/last granted requester.
- arb_busy, output, 1, high in every state except IDLE.
- tx_data, output, 8, byte to transmitter; held stable from tx_start until tx_done.
- tx_start, output, 1, one-cycle start pulse to transmitter.
- tx_busy, input, 1, transmitter is shifting a frame.
- tx_done, input, 1, one-cycle pulse at end of stop bit.

Behaviour:
- Reset (async assert, sync release): state = IDLE; req_ack = 0; tx_start = 0; tx_data = 0x00; arb_busy = 0; grant_id = N_REQ-1; lock flag = 0; hold counter = 0. This makes requester 0 highest priority after reset.
- All outputs are registered.
- States: IDLE, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE, req != 0:
  - Winner w = first set bit of req, searching circularly from grant_id+1.
  - Next cycle: grant_id = w; tx_data = req_data[w]; req_ack[w] = 1 for one cycle; tx_start = 1 for one cycle; last_l = req_last[w]. Go to WAIT_BUSY.
  - Latency from req to ack/tx_start is 1 cycle.
- WAIT_BUSY:
  - tx_busy = 1: go to WAIT_DONE.
  - tx_done = 1 (same or earlier cycle than busy): treat as done and apply the WAIT_DONE exit rule directly.
- WAIT_DONE, tx_done = 1:
  - LOCK_EN = 1 and last_l = 0: go to HOLD and clear the hold counter.
  - Otherwise: go to IDLE.
  - tx_done while tx_busy = 0 is still accepted.
- HOLD:
  - Only req[grant_id] is considered; other requests wait.
  - req[grant_id] = 1: issue exactly as in IDLE with w = grant_id, go to WAIT_BUSY.
  - Otherwise increment the hold counter. At HOLD_TO, go to IDLE (lock dropped, normal rotation resumes from grant_id+1).
- Requester protocol:
  - req may drop or present the next byte in the cycle after req_ack.
  - The arbiter samples req only in IDLE/HOLD, so no byte is double-acked.
  - A req dropped before ack is lost without error.
- Simultaneous requests: exactly one req_ack bit is ever set in a cycle.
- N_REQ = 1 degenerates to pass-through with the same timing.
- Reset mid-frame: all state is cleared immediately. A byte already started in the transmitter completes there, but any tx_done it produces after reset is ignored in IDLE.
- No combinational path from req to req_ack or tx_start.

Decomposition:
- Shared uart package holds:
  - state encoding localparams (IDLE, WAIT_BUSY, WAIT_DONE, HOLD);
  - the byte width constant (8);
  - a clog2 function used for GID_W and the hold counter width.
- One natural sub-module: rr_pick. Combinational round-robin priority picker with inputs req[N_REQ] and last grant index, and outputs winner index and valid.

Test Plan:
- Single requester: req[2] = 1, data 0x5A, last = 1 → next cycle req_ack = 0100, tx_start pulse, tx_data = 0x5A, grant_id = 2. On tx_done → IDLE, arb_busy = 0.
- Fairness: req = 1111 held continuously, LOCK_EN = 0, each tx_done 20 cycles after start → grant order 0,1,2,3,0,1. Exactly one ack per byte.
- Packet lock: req[1] sends 0x01, 0x02, 0x03 (last on 0x03) while req[3] is held → all three bytes from requester 1 go out consecutively, then requester 3 is granted.
- Hold timeout: HOLD_TO = 16. Requester 0 sends one byte with last = 0 then drops req, req[2] = 1 → requester 2 is granted only after 16 idle HOLD cycles, and in the cycle following the timeout.
- Fast transmitter: tx_done pulses while tx_busy never rises → arbiter still leaves WAIT_BUSY and issues the next pending byte.
- Async reset asserted during WAIT_DONE → all outputs 0, grant_id = N_REQ-1 immediately. After release with req = 1111, requester 0 is granted first.
